board_io_conditioner: RTL and testbench

Parametrised front-end conditioning for the DE-board user I/O. It sits between the raw pins (SW, KEY, reset switch) and the core's io_sw_i/io_btn_i/rst_ni ports. It provides:
- a multi-stage reset synchroniser (asynchronous assert, synchronous deassert);
- N-stage synchronisers for the slide switches;
- per-button synchronise-and-debounce logic with one-cycle press and release pulses.

All channel counts, stage depths and the debounce window are parameters.

---
 rtl/board_io_conditioner.sv | 134 +++++++++++++
 tb/tb_board_io_conditioner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_conditioner.sv
// Front-end conditioning for board user I/O: reset synchroniser, switch
// synchronisers and per-button synchronise + debounce with press/release pulses.
module board_io_conditioner #(
  parameter int NUM_SW          = 9,
  parameter int NUM_BTN         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int RST_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SW-1:0]  sw_i,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic               rst_n_sync_o,
  output logic [NUM_SW-1:0]  sw_o,
  output logic [NUM_BTN-1:0] btn_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [NUM_BTN-1:0] btn_release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic BTN_IDLE = (BTN_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_e;

  // Per-channel debounce state kept in one struct so checkers can bind to it.
  typedef struct packed {
    deb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             btn;
    logic             press;
    logic             rel;
  } deb_t;

  logic [RST_STAGES-1:0]               r_rst_sync;
  logic [SYNC_STAGES-1:0][NUM_SW-1:0]  r_sw_sync;
  logic [SYNC_STAGES-1:0][NUM_BTN-1:0] r_btn_sync;
  logic [NUM_BTN-1:0]                  w_btn_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[RST_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_sync_o = r_rst_sync[RST_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sw_sync <= '0;
    end else begin
      r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], sw_i};
    end
  end

  assign sw_o = r_sw_sync[SYNC_STAGES-1];

  // Button chains reset to the released level so reset exit looks idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_btn_sync <= {SYNC_STAGES{{NUM_BTN{BTN_IDLE}}}};
    end else begin
      r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], btn_i};
    end
  end

  // Normalise to 1 = pressed.
  assign w_btn_s = r_btn_sync[SYNC_STAGES-1] ^ {NUM_BTN{BTN_IDLE}};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    deb_t r_deb;

    // cnt holds the number of consecutive differing edges already seen, so the
    // state flips on the DEBOUNCE_CYCLES-th such edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_deb.state <= ST_STABLE;
        r_deb.cnt   <= '0;
        r_deb.btn   <= 1'b0;
        r_deb.press <= 1'b0;
        r_deb.rel   <= 1'b0;
      end else begin
        r_deb.press <= 1'b0;
        r_deb.rel   <= 1'b0;
        case (r_deb.state)
          ST_STABLE: begin
            r_deb.cnt <= '0;
            if (w_btn_s[g] != r_deb.btn) begin
              if (DEBOUNCE_CYCLES == 1) begin
                r_deb.btn   <= w_btn_s[g];
                r_deb.press <= w_btn_s[g];
                r_deb.rel   <= ~w_btn_s[g];
              end else begin
                r_deb.state <= ST_COUNTING;
                r_deb.cnt   <= CNT_ONE;
              end
            end
          end
          ST_COUNTING: begin
            if (w_btn_s[g] == r_deb.btn) begin
              r_deb.state <= ST_STABLE;
              r_deb.cnt   <= '0;
            end else if (r_deb.cnt == CNT_LAST) begin
              r_deb.state <= ST_STABLE;
              r_deb.cnt   <= '0;
              r_deb.btn   <= w_btn_s[g];
              r_deb.press <= w_btn_s[g];
              r_deb.rel   <= ~w_btn_s[g];
            end else begin
              r_deb.cnt <= r_deb.cnt + CNT_ONE;
            end
          end
          default: begin
            r_deb.state <= ST_STABLE;
            r_deb.cnt   <= '0;
          end
        endcase
      end
    end

    assign btn_o[g]         = r_deb.btn;
    assign btn_press_o[g]   = r_deb.press;
    assign btn_release_o[g] = r_deb.rel;
  end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Bench for board_io_conditioner: directed scenarios plus random stimulus,
// checked against a history/run-length reference model.
module tb_board_io_conditioner;

  localparam int NUM_SW  = 9;
  localparam int NUM_BTN = 4;
  localparam int SYNC    = 2;
  localparam int RSTS    = 2;
  localparam int DEB     = 8;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [NUM_SW-1:0]  sw_i;
  logic [NUM_BTN-1:0] btn_i;
  logic               rst_n_sync_o;
  logic [NUM_SW-1:0]  sw_o;
  logic [NUM_BTN-1:0] btn_o;
  logic [NUM_BTN-1:0] btn_press_o;
  logic [NUM_BTN-1:0] btn_release_o;

  board_io_conditioner #(
    .NUM_SW(NUM_SW), .NUM_BTN(NUM_BTN), .SYNC_STAGES(SYNC), .RST_STAGES(RSTS),
    .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sw_i(sw_i), .btn_i(btn_i),
    .rst_n_sync_o(rst_n_sync_o), .sw_o(sw_o), .btn_o(btn_o),
    .btn_press_o(btn_press_o), .btn_release_o(btn_release_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: raw-sample history and per-button run lengths.
  logic [NUM_SW-1:0]  m_sw_q[$];
  logic [NUM_BTN-1:0] m_btn_q[$];
  int                 m_rst_edges;
  int                 m_run[NUM_BTN];
  logic [NUM_BTN-1:0] m_btn, m_press, m_rel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sw_q = {};
    m_btn_q = {};
    for (int i = 0; i < SYNC; i++) begin
      m_sw_q.push_back('0);
      m_btn_q.push_back('1);
    end
    m_rst_edges = 0;
    m_btn = '0;
    m_press = '0;
    m_rel = '0;
    for (int i = 0; i < NUM_BTN; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [NUM_BTN-1:0] s;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    if (m_rst_edges < RSTS) m_rst_edges++;
    s = ~m_btn_q[0];
    m_btn_q.push_back(btn_i);
    m_btn_q.delete(0);
    m_sw_q.push_back(sw_i);
    m_sw_q.delete(0);
    m_press = '0;
    m_rel = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (s[i] != m_btn[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_btn[i] = s[i];
          m_press[i] = s[i];
          m_rel[i] = ~s[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    check("rst_n_sync", 32'(rst_n_sync_o), 32'(m_rst_edges >= RSTS));
    check("sw_o", 32'(sw_o), 32'(m_sw_q[0]));
    check("btn_o", 32'(btn_o), 32'(m_btn));
    check("btn_press", 32'(btn_press_o), 32'(m_press));
    check("btn_release", 32'(btn_release_o), 32'(m_rel));
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic assert_reset();
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    rst_ni = 1'b1;
    sw_i = '0;
    btn_i = '1;
    #1;
    assert_reset();
    ticks(3);

    // 1: reset synchroniser release and asynchronous assertion
    rst_ni = 1'b1;
    tick();
    check("rst_edge1", 32'(rst_n_sync_o), 32'd0);
    tick();
    check("rst_edge2", 32'(rst_n_sync_o), 32'd1);
    ticks(2);
    assert_reset();
    check("rst_async", 32'(rst_n_sync_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    ticks(3);

    // 2: switch synchroniser latency
    sw_i = 9'h1A5;
    tick();
    check("sw_edge1", 32'(sw_o), 32'h000);
    tick();
    check("sw_edge2", 32'(sw_o), 32'h1A5);
    ticks(2);

    // 3: clean press and release on button 0
    btn_i = 4'b1110;
    for (int e = 1; e <= 11; e++) begin
      tick();
      check("b0_press", 32'(btn_press_o[0]), 32'(e == 10));
      check("b0_state", 32'(btn_o[0]), 32'(e >= 10));
    end
    btn_i = 4'b1111;
    for (int e = 1; e <= 11; e++) begin
      tick();
      check("b0_release", 32'(btn_release_o[0]), 32'(e == 10));
      check("b0_state_rel", 32'(btn_o[0]), 32'(e < 10));
    end

    // 4: bounce on button 1 discards the partial count
    btn_i = 4'b1101;
    ticks(5);
    btn_i = 4'b1111;
    tick();
    btn_i = 4'b1101;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check("b1_bounce", 32'(btn_press_o[1]), 32'(e == 10));
    end
    btn_i = 4'b1111;
    ticks(12);

    // 5: simultaneous press, then independence from bouncing channel 2
    btn_i = 4'b0000;
    ticks(9);
    tick();
    check("all_btn", 32'(btn_o), 32'hF);
    check("all_press", 32'(btn_press_o), 32'hF);
    btn_i = 4'b1111;
    ticks(12);
    for (int e = 1; e <= 12; e++) begin
      btn_i = {1'b0, e[0], 2'b00};
      tick();
      if (e == 10) check("ind_press", 32'(btn_press_o), 32'b1011);
    end
    btn_i = 4'b1111;
    ticks(12);

    // 6: reset in the middle of a count with button 2 held through it
    btn_i = 4'b1011;
    ticks(7);
    assert_reset();
    check("mid_rst_btn", 32'(btn_o), 32'h0);
    for (int e = 0; e < 3; e++) begin
      tick();
      check("in_rst_press", 32'(btn_press_o), 32'h0);
    end
    rst_ni = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      check("b2_after_rst", 32'(btn_press_o), (e == 10) ? 32'b0100 : 32'h0);
    end
    btn_i = 4'b1111;
    ticks(12);

    // Random phase: buttons flip occasionally, switches change freely
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_BTN; i++)
        if ($urandom_range(0, 15) == 0) btn_i[i] = ~btn_i[i];
      sw_i = NUM_SW'($urandom);
      if (c == 200) begin
        assert_reset();
        tick();
        rst_ni = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
